pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage 16-bit CPU (F,D,E,M,W).

---
 rtl/pipeline_hazard_ctrl_if.sv | 51 +++++
 rtl/pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_if
//  Brief    : Bundle between the 5-stage pipeline datapath and the hazard
//             controller (hazard sources in, stall/flush/debug out).
//  Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
    // Hazard sources from the datapath
    logic [2:0]  rsD;
    logic [2:0]  rtD;
    logic        useRtD;
    logic        haltD;
    logic        memReadE;
    logic        regWriteE;
    logic [2:0]  rdE;
    logic        branchTakenE;
    logic        memReqM;
    logic        memReadyM;
    logic        resume;

    // Pipeline register controls and debug visibility
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        stallM;
    logic        flushD;
    logic        flushE;
    logic        flushW;
    logic        memErr;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] stallCnt;

    // Datapath side: supplies hazard sources, consumes controls
    modport master (
        output rsD, rtD, useRtD, haltD, memReadE, regWriteE, rdE,
               branchTakenE, memReqM, memReadyM, resume,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               memErr, halted, state, stallCnt
    );

    // Controller side
    modport slave (
        input  rsD, rtD, useRtD, haltD, memReadE, regWriteE, rdE,
               branchTakenE, memReqM, memReadyM, resume,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               memErr, halted, state, stallCnt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Stall/flush sequencer for the F/D/E/M/W pipeline. Handles
//             load-use, taken-branch redirect, data-memory wait (with
//             timeout), HALT drain/freeze and a saturating stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REDIRECT_CYC = 1,    // flushD cycles after a taken branch (1..7)
    parameter int MEM_TIMEOUT  = 255,  // memory-wait cycles before memErr (1..255)
    parameter int DRAIN_CYC    = 3     // E/M/W drain cycles after HALT (1..7)
) (
    input  logic                  clk,
    input  logic                  reset,   // asynchronous, active-low
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [2:0] c_RUN   = 3'd0;
    localparam logic [2:0] c_REDIR = 3'd1;
    localparam logic [2:0] c_MEMW  = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_HALT  = 3'd4;

    localparam logic [7:0] c_REDIR_LOAD = 8'(REDIRECT_CYC - 1);
    localparam logic [7:0] c_DRAIN_LOAD = 8'(DRAIN_CYC);
    // Last wait count before the timeout fires (wait cycle N sees count N-1)
    localparam logic [7:0] c_TMO_LAST   = 8'(MEM_TIMEOUT - 1);
    localparam logic       c_TMO_FIRST  = (MEM_TIMEOUT == 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] r_stall_cnt;

    logic w_lu;
    logic w_mw;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic w_flush_d, w_flush_e, w_flush_w;
    logic w_mem_err, w_halted;

    assign w_lu = hz.memReadE & hz.regWriteE & (hz.rdE != 3'd0) &
                  ((hz.rdE == hz.rsD) | (hz.useRtD & (hz.rdE == hz.rtD)));
    assign w_mw = hz.memReqM & ~hz.memReadyM;

    // State and shared sequencing counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_RUN;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and counter; priority mw > branch > halt > load-use
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_RUN, c_REDIR: begin
                if (w_mw) begin
                    // Branch in E is re-presented once the memory stall ends
                    w_state_nxt = c_TMO_FIRST ? c_HALT : c_MEMW;
                    w_cnt_nxt   = c_TMO_FIRST ? 8'd0 : 8'd1;
                end else if (hz.branchTakenE) begin
                    w_state_nxt = (REDIRECT_CYC > 1) ? c_REDIR : c_RUN;
                    w_cnt_nxt   = c_REDIR_LOAD;
                end else if (r_state == c_REDIR) begin
                    // D is being flushed, so halt and load-use are irrelevant
                    if (r_cnt <= 8'd1) begin
                        w_state_nxt = c_RUN;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 8'd1;
                    end
                end else if (hz.haltD) begin
                    w_state_nxt = c_DRAIN;
                    w_cnt_nxt   = c_DRAIN_LOAD;
                end
            end
            c_MEMW: begin
                if (!w_mw) begin
                    w_state_nxt = c_RUN;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt >= c_TMO_LAST) begin
                    w_state_nxt = c_HALT;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            c_DRAIN: begin
                // A memory wait freezes the drain countdown
                if (!w_mw) begin
                    if (r_cnt <= 8'd1) begin
                        w_state_nxt = c_HALT;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 8'd1;
                    end
                end
            end
            c_HALT: begin
                if (hz.resume) begin
                    w_state_nxt = c_RUN;
                    w_cnt_nxt   = 8'd0;
                end
            end
            default: begin
                w_state_nxt = c_RUN;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Stall/flush decode from current state and live hazards
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        w_mem_err = 1'b0;
        w_halted  = 1'b0;
        case (r_state)
            c_RUN, c_REDIR: begin
                if (w_mw) begin
                    {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
                    w_flush_w = 1'b1;
                    w_mem_err = c_TMO_FIRST;
                end else if (hz.branchTakenE) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (r_state == c_REDIR) begin
                    w_flush_d = 1'b1;
                end else if (hz.haltD) begin
                    w_stall_f = 1'b1;
                    w_flush_d = 1'b1;
                end else if (w_lu) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_flush_e = 1'b1;
                end
            end
            c_MEMW: begin
                if (w_mw) begin
                    {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
                    w_flush_w = 1'b1;
                    w_mem_err = (r_cnt >= c_TMO_LAST);
                end
            end
            c_DRAIN: begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                if (w_mw) begin
                    w_stall_e = 1'b1;
                    w_stall_m = 1'b1;
                    w_flush_w = 1'b1;
                end
            end
            c_HALT: begin
                if (!hz.resume) begin
                    {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
                    w_flush_w = 1'b1;
                    w_halted  = 1'b1;
                end
            end
            default: begin
                w_stall_f = 1'b0;
            end
        endcase
    end

    // Saturating count of fetch-stalled cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
        end else if (hz.stallF && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // Outputs are forced low while reset is held, whatever the inputs do
    assign hz.stallF   = reset & w_stall_f;
    assign hz.stallD   = reset & w_stall_d;
    assign hz.stallE   = reset & w_stall_e;
    assign hz.stallM   = reset & w_stall_m;
    assign hz.flushD   = reset & w_flush_d;
    assign hz.flushE   = reset & w_flush_e;
    assign hz.flushW   = reset & w_flush_w;
    assign hz.memErr   = reset & w_mem_err;
    assign hz.halted   = reset & w_halted;
    assign hz.state    = r_state;
    assign hz.stallCnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Self-checking bench for pipeline_hazard_ctrl with
//             REDIRECT_CYC=2, MEM_TIMEOUT=8, DRAIN_CYC=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [2:0] rsD;
        logic [2:0] rtD;
        logic       useRtD;
        logic       haltD;
        logic       memReadE;
        logic       regWriteE;
        logic [2:0] rdE;
        logic       br;
        logic       memReqM;
        logic       memReadyM;
        logic       resume;
    } in_t;

    typedef struct packed {
        logic [3:0]  st;      // {stallF, stallD, stallE, stallM}
        logic [2:0]  fl;      // {flushD, flushE, flushW}
        logic        memErr;
        logic        halted;
        logic [2:0]  state;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        string nm;
        in_t   i;
        out_t  o;
    } vec_t;

    localparam logic [2:0] c_RUN   = 3'd0;
    localparam logic [2:0] c_REDIR = 3'd1;
    localparam logic [2:0] c_MEMW  = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_HALT  = 3'd4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] m_cnt  = 16'd0;
    out_t        q_exp[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .REDIRECT_CYC (2),
        .MEM_TIMEOUT  (8),
        .DRAIN_CYC    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    function automatic in_t mk(input logic [2:0] rs, input logic [2:0] rt, input logic urt,
                               input logic hlt, input logic mrd, input logic rwe,
                               input logic [2:0] rd, input logic br, input logic mreq,
                               input logic mrdy, input logic res);
        in_t v;
        v.rsD = rs; v.rtD = rt; v.useRtD = urt; v.haltD = hlt;
        v.memReadE = mrd; v.regWriteE = rwe; v.rdE = rd; v.br = br;
        v.memReqM = mreq; v.memReadyM = mrdy; v.resume = res;
        return v;
    endfunction

    function automatic vec_t row(input string nm, input in_t i, input logic [3:0] st,
                                 input logic [2:0] fl, input logic me, input logic ha,
                                 input logic [2:0] s);
        vec_t v;
        v.nm = nm; v.i = i;
        v.o.st = st; v.o.fl = fl; v.o.memErr = me; v.o.halted = ha;
        v.o.state = s; v.o.cnt = 16'd0;
        return v;
    endfunction

    task automatic drive(input in_t i);
        hz.rsD = i.rsD; hz.rtD = i.rtD; hz.useRtD = i.useRtD; hz.haltD = i.haltD;
        hz.memReadE = i.memReadE; hz.regWriteE = i.regWriteE; hz.rdE = i.rdE;
        hz.branchTakenE = i.br; hz.memReqM = i.memReqM; hz.memReadyM = i.memReadyM;
        hz.resume = i.resume;
    endtask

    function automatic out_t sample();
        out_t a;
        a.st     = {hz.stallF, hz.stallD, hz.stallE, hz.stallM};
        a.fl     = {hz.flushD, hz.flushE, hz.flushW};
        a.memErr = hz.memErr;
        a.halted = hz.halted;
        a.state  = hz.state;
        a.cnt    = hz.stallCnt;
        return a;
    endfunction

    task automatic check(input string nm);
        out_t e;
        out_t a;
        n_chk++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = q_exp.pop_front();
            a = sample();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got st=%b fl=%b err=%b hlt=%b state=%0d cnt=%0d, want st=%b fl=%b err=%b hlt=%b state=%0d cnt=%0d",
                         nm, a.st, a.fl, a.memErr, a.halted, a.state, a.cnt,
                         e.st, e.fl, e.memErr, e.halted, e.state, e.cnt);
            end
        end
    endtask

    // One clock cycle: drive after the edge, sample mid-cycle, advance the stall model
    task automatic step(input vec_t v);
        out_t e;
        @(posedge clk);
        #1;
        drive(v.i);
        e     = v.o;
        e.cnt = m_cnt;
        q_exp.push_back(e);
        #2;
        check(v.nm);
        if (v.o.st[3] && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    endtask

    initial begin
        in_t  idle;
        in_t  lu3;
        in_t  mwait;
        in_t  mdone;
        in_t  halt;
        out_t zero;

        idle  = mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        lu3   = mk(3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        mwait = mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        mdone = mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        halt  = mk(3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        zero  = '0;

        // Load-use
        tbl.push_back(row("idle",        idle, 4'b0000, 3'b000, 0, 0, c_RUN));
        tbl.push_back(row("lu_rs",       lu3,  4'b1100, 3'b010, 0, 0, c_RUN));
        tbl.push_back(row("lu_bubble",   idle, 4'b0000, 3'b000, 0, 0, c_RUN));
        tbl.push_back(row("lu_rd0",      mk(0,0,0,0,1,1,0,0,0,0,0), 4'b0000, 3'b000, 0, 0, c_RUN));
        tbl.push_back(row("lu_rt",       mk(1,5,1,0,1,1,5,0,0,0,0), 4'b1100, 3'b010, 0, 0, c_RUN));
        tbl.push_back(row("lu_rt_unused",mk(1,5,0,0,1,1,5,0,0,0,0), 4'b0000, 3'b000, 0, 0, c_RUN));
        tbl.push_back(row("lu_no_wr",    mk(3,0,0,0,1,0,3,0,0,0,0), 4'b0000, 3'b000, 0, 0, c_RUN));
        // Branch redirect; REDIR ignores halt and load-use
        tbl.push_back(row("br_N",        mk(0,0,0,0,0,0,0,1,0,0,0), 4'b0000, 3'b110, 0, 0, c_RUN));
        tbl.push_back(row("br_N1",       mk(3,0,0,1,1,1,3,0,0,0,0), 4'b0000, 3'b100, 0, 0, c_REDIR));
        tbl.push_back(row("br_N2",       idle, 4'b0000, 3'b000, 0, 0, c_RUN));
        // Memory wait, 4 cycles, branch during wait does not flush
        tbl.push_back(row("mw_1",        mwait, 4'b1111, 3'b001, 0, 0, c_RUN));
        tbl.push_back(row("mw_2",        mwait, 4'b1111, 3'b001, 0, 0, c_MEMW));
        tbl.push_back(row("mw_3_br",     mk(0,0,0,0,0,0,0,1,1,0,0), 4'b1111, 3'b001, 0, 0, c_MEMW));
        tbl.push_back(row("mw_4",        mwait, 4'b1111, 3'b001, 0, 0, c_MEMW));
        tbl.push_back(row("mw_done",     mdone, 4'b0000, 3'b000, 0, 0, c_MEMW));
        tbl.push_back(row("mw_after",    idle, 4'b0000, 3'b000, 0, 0, c_RUN));
        // Branch deferred behind a memory wait, then re-presented
        tbl.push_back(row("mwbr_wait",   mk(0,0,0,0,0,0,0,1,1,0,0), 4'b1111, 3'b001, 0, 0, c_RUN));
        tbl.push_back(row("mwbr_done",   mk(0,0,0,0,0,0,0,1,1,1,0), 4'b0000, 3'b000, 0, 0, c_MEMW));
        tbl.push_back(row("mwbr_branch", mk(0,0,0,0,0,0,0,1,0,0,0), 4'b0000, 3'b110, 0, 0, c_RUN));
        tbl.push_back(row("mwbr_redir",  idle, 4'b0000, 3'b100, 0, 0, c_REDIR));
        tbl.push_back(row("mwbr_run",    idle, 4'b0000, 3'b000, 0, 0, c_RUN));
        // Timeout after 8 wait cycles
        tbl.push_back(row("tmo_w1",      mwait, 4'b1111, 3'b001, 0, 0, c_RUN));
        for (int k = 2; k <= 7; k++)
            tbl.push_back(row($sformatf("tmo_w%0d", k), mwait, 4'b1111, 3'b001, 0, 0, c_MEMW));
        tbl.push_back(row("tmo_w8_err",  mwait, 4'b1111, 3'b001, 1, 0, c_MEMW));
        tbl.push_back(row("tmo_halt",    idle, 4'b1111, 3'b001, 0, 1, c_HALT));
        tbl.push_back(row("tmo_halt2",   idle, 4'b1111, 3'b001, 0, 1, c_HALT));
        tbl.push_back(row("tmo_resume",  mk(0,0,0,0,0,0,0,0,0,0,1), 4'b0000, 3'b000, 0, 0, c_HALT));
        tbl.push_back(row("tmo_run",     idle, 4'b0000, 3'b000, 0, 0, c_RUN));
        // HALT with a memory wait pausing the drain
        tbl.push_back(row("hlt_req",     halt, 4'b1000, 3'b100, 0, 0, c_RUN));
        tbl.push_back(row("drain_1",     idle, 4'b1100, 3'b000, 0, 0, c_DRAIN));
        tbl.push_back(row("drain_mw",    mwait, 4'b1111, 3'b001, 0, 0, c_DRAIN));
        tbl.push_back(row("drain_2",     idle, 4'b1100, 3'b000, 0, 0, c_DRAIN));
        tbl.push_back(row("drain_3",     idle, 4'b1100, 3'b000, 0, 0, c_DRAIN));
        tbl.push_back(row("hlt_frozen",  idle, 4'b1111, 3'b001, 0, 1, c_HALT));
        tbl.push_back(row("hlt_resume",  mk(0,0,0,0,0,0,0,0,0,0,1), 4'b0000, 3'b000, 0, 0, c_HALT));
        tbl.push_back(row("hlt_run",     idle, 4'b0000, 3'b000, 0, 0, c_RUN));
        // Plain HALT, exactly three drain cycles
        tbl.push_back(row("h3_req",      halt, 4'b1000, 3'b100, 0, 0, c_RUN));
        tbl.push_back(row("h3_d1",       idle, 4'b1100, 3'b000, 0, 0, c_DRAIN));
        tbl.push_back(row("h3_d2",       idle, 4'b1100, 3'b000, 0, 0, c_DRAIN));
        tbl.push_back(row("h3_d3",       idle, 4'b1100, 3'b000, 0, 0, c_DRAIN));
        tbl.push_back(row("h3_halted",   idle, 4'b1111, 3'b001, 0, 1, c_HALT));
        tbl.push_back(row("h3_resume",   mk(0,0,0,0,0,0,0,0,0,0,1), 4'b0000, 3'b000, 0, 0, c_HALT));
        tbl.push_back(row("h3_run",      idle, 4'b0000, 3'b000, 0, 0, c_RUN));

        // Reset held with live hazards on the inputs: everything must read 0
        drive(lu3);
        #3;
        q_exp.push_back(zero);
        check("reset_state");
        drive(mwait);
        #1;
        q_exp.push_back(zero);
        check("reset_mw_gated");
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        m_cnt = 16'd0;

        foreach (tbl[k]) step(tbl[k]);

        // Reset asserted in the middle of DRAIN
        step(row("rst_hlt_req", halt, 4'b1000, 3'b100, 0, 0, c_RUN));
        step(row("rst_drain",   idle, 4'b1100, 3'b000, 0, 0, c_DRAIN));
        @(posedge clk);
        #1;
        drive(mwait);
        #1;
        reset = 1'b0;
        #1;
        q_exp.push_back(zero);
        check("rst_mid_drain");
        m_cnt = 16'd0;
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        step(row("rst_after", idle, 4'b0000, 3'b000, 0, 0, c_RUN));
        step(row("rst_lu",    lu3,  4'b1100, 3'b010, 0, 0, c_RUN));
        step(row("rst_cnt1",  idle, 4'b0000, 3'b000, 0, 0, c_RUN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no completion, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
